// File: rtl/vector_chunk_streamer.sv
// Streams one dot product's row and vector chunks from memory to a
// dot-product unit, then captures the unit's result.
// Optional feature macro: ZERO_PAD_EN zeroes the unused lanes of the last chunk.
module vector_chunk_streamer #(
    parameter int unsigned number_of_equations_per_cluster = 16,
    parameter int unsigned element_width                   = 32,
    parameter int unsigned no_of_units                     = 8,
    parameter int unsigned addr_width                      = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   rd_en,
    output logic [addr_width-1:0]                  rd_addr,
    input  logic [element_width*no_of_units-1:0]   rd_data_row,
    input  logic [element_width*no_of_units-1:0]   rd_data_vec,
    output logic [element_width*no_of_units-1:0]   first_row_plus_additional,
    output logic [element_width*no_of_units-1:0]   vector2,
    output logic                                   outsider_read_now,
    input  logic [element_width-1:0]              result,
    input  logic                                   finish,
    output logic [element_width-1:0]              dot_result
);

    localparam int unsigned N  = number_of_equations_per_cluster;
    localparam int unsigned U  = no_of_units;
    localparam int unsigned W  = element_width;
    localparam int unsigned DW = W * U;
    localparam int unsigned C  = (N + U - 1) / U;
    localparam int unsigned K  = N % U;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READ     = 2'd1,
        DRAIN    = 2'd2,
        WAIT_FIN = 2'd3
    } state_t;

    state_t                state;
    logic [addr_width-1:0] cnt;        // next chunk address to issue
    logic                  rd_last;    // current rd_en is the last chunk
    logic                  data_vld;   // memory data valid this cycle
    logic                  data_last;  // memory data is the last chunk
    logic                  out_last;   // presented chunk is the last one
    logic                  fin_seen;   // result captured, done next edge
    logic [DW-1:0]         lane_mask_c;

`ifdef ZERO_PAD_EN
    // Keeps lanes 0..K-1 of the last chunk (all lanes when K is zero).
    function automatic logic [DW-1:0] build_last_mask();
        logic [DW-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < U; i++) begin
            if (K == 0 || i < K) m[i*W +: W] = {W{1'b1}};
        end
        return m;
    endfunction

    localparam logic [DW-1:0] LAST_MASK = build_last_mask();

    // Mask applied to incoming memory data.
    assign lane_mask_c = data_last ? LAST_MASK : {DW{1'b1}};
`else
    // Memory data passes through unmasked.
    assign lane_mask_c = {DW{1'b1}};
`endif

    // Control FSM: issues chunk reads, waits for the unit, captures result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            rd_last    <= 1'b0;
            fin_seen   <= 1'b0;
            dot_result <= '0;
        end else begin
            done     <= fin_seen;
            fin_seen <= 1'b0;
            rd_en    <= 1'b0;
            rd_last  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Chunk 0 is issued on the accepting edge.
                        busy    <= 1'b1;
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                        cnt     <= addr_width'(1);
                        rd_last <= (C == 1);
                        state   <= (C == 1) ? DRAIN : READ;
                    end
                end
                READ: begin
                    rd_en   <= 1'b1;
                    rd_addr <= cnt;
                    cnt     <= cnt + addr_width'(1);
                    if (cnt == addr_width'(C - 1)) begin
                        rd_last <= 1'b1;
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (outsider_read_now && out_last) state <= WAIT_FIN;
                end
                WAIT_FIN: begin
                    if (finish) begin
                        dot_result <= result;
                        fin_seen   <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data path: aligns memory data and presents each chunk for one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_vld                  <= 1'b0;
            data_last                 <= 1'b0;
            out_last                  <= 1'b0;
            outsider_read_now         <= 1'b0;
            first_row_plus_additional <= '0;
            vector2                   <= '0;
        end else begin
            data_vld          <= rd_en;
            data_last         <= rd_en & rd_last;
            outsider_read_now <= data_vld;
            out_last          <= data_vld & data_last;
            if (data_vld) begin
                first_row_plus_additional <= rd_data_row & lane_mask_c;
                vector2                   <= rd_data_vec & lane_mask_c;
            end
        end
    end

endmodule

// File: tb/tb_vector_chunk_streamer.sv
// Scoreboard bench for vector_chunk_streamer (N=12, U=8: two chunks, last
// chunk has four live lanes). Build with +define+ZERO_PAD_EN to cover masking.
module tb_vector_chunk_streamer;

    localparam int N  = 12;
    localparam int U  = 8;
    localparam int W  = 32;
    localparam int AW = 8;
    localparam int DW = W * U;
    localparam int C  = (N + U - 1) / U;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data_row;
    logic [DW-1:0] rd_data_vec;
    logic [DW-1:0] first_row_plus_additional;
    logic [DW-1:0] vector2;
    logic          outsider_read_now;
    logic [W-1:0]  result;
    logic          finish;
    logic [W-1:0]  dot_result;

    vector_chunk_streamer #(
        .number_of_equations_per_cluster(N),
        .element_width(W),
        .no_of_units(U),
        .addr_width(AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .busy(busy),
        .done(done),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_data_row(rd_data_row),
        .rd_data_vec(rd_data_vec),
        .first_row_plus_additional(first_row_plus_additional),
        .vector2(vector2),
        .outsider_read_now(outsider_read_now),
        .result(result),
        .finish(finish),
        .dot_result(dot_result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory with one cycle read latency.
    logic [DW-1:0] mem_row [0:(1<<AW)-1];
    logic [DW-1:0] mem_vec [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_row <= mem_row[rd_addr];
            rd_data_vec <= mem_vec[rd_addr];
        end
    end

    int            n_checks = 0;
    int            n_fail   = 0;
    int            exp_addr_q[$];
    int            lat_q[$];
    logic [DW-1:0] exp_row_q[$];
    logic [DW-1:0] exp_vec_q[$];
    logic [W-1:0]  exp_res_q[$];
    int            exp_done_q[$];
    logic [DW-1:0] last_row = '0;
    logic [DW-1:0] last_vec = '0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event not expected or timed out (cycle %0d)", name, cyc);
    endtask

    // Reference: element e of the vector lives in chunk e/U, lane e%U.
    // Elements at index N and beyond are padding.
    function automatic logic [DW-1:0] model_chunk(input logic [DW-1:0] raw, input int c);
        logic [DW-1:0] r;
        r = raw;
`ifdef ZERO_PAD_EN
        for (int l = 0; l < U; l++) begin
            if (c * U + l >= N) r[l*W +: W] = '0;
        end
`else
        if (c < 0) r = '0;
`endif
        return r;
    endfunction

    // Monitor: compares everything the DUT presents against the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            if (rd_en) begin
                if (exp_addr_q.size() == 0) fail_event("rd_en");
                else check("rd_addr", DW'(rd_addr), DW'(exp_addr_q.pop_front()));
                lat_q.push_back(cyc);
            end
            if (outsider_read_now) begin
                if (exp_row_q.size() == 0 || lat_q.size() == 0) begin
                    fail_event("outsider_read_now");
                end else begin
                    last_row = exp_row_q.pop_front();
                    last_vec = exp_vec_q.pop_front();
                    check("row_chunk", first_row_plus_additional, last_row);
                    check("vec_chunk", vector2, last_vec);
                    check("chunk_latency", DW'(cyc - lat_q.pop_front()), DW'(2));
                end
            end else begin
                check("row_hold", first_row_plus_additional, last_row);
                check("vec_hold", vector2, last_vec);
            end
            if (done) begin
                if (exp_res_q.size() == 0) begin
                    fail_event("done");
                end else begin
                    check("dot_result", DW'(dot_result), DW'(exp_res_q.pop_front()));
                    check("done_cycle", DW'(cyc), DW'(exp_done_q.pop_front()));
                    check("busy_at_done", DW'(busy), DW'(0));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, DW'(busy), '0);
        check({tag, "_done"}, DW'(done), '0);
        check({tag, "_rd_en"}, DW'(rd_en), '0);
        check({tag, "_rd_addr"}, DW'(rd_addr), '0);
        check({tag, "_outsider"}, DW'(outsider_read_now), '0);
        check({tag, "_row"}, first_row_plus_additional, '0);
        check({tag, "_vec"}, vector2, '0);
        check({tag, "_dot_result"}, DW'(dot_result), '0);
    endtask

    // Loads memory for one operation and queues the expected chunk stream.
    task automatic load_op(input bit all_ones);
        for (int c = 0; c < C; c++) begin
            for (int l = 0; l < U; l++) begin
                mem_row[c][l*W +: W] = all_ones ? 32'hFFFF_FFFF : $urandom();
                mem_vec[c][l*W +: W] = all_ones ? 32'hFFFF_FFFF : $urandom();
            end
            exp_addr_q.push_back(c);
            exp_row_q.push_back(model_chunk(mem_row[c], c));
            exp_vec_q.push_back(model_chunk(mem_vec[c], c));
        end
    endtask

    task automatic run_op(input bit all_ones, input bit hold_start,
                          input bit bogus_finish, input bit fin_with_start);
        logic [W-1:0] res;
        bit           ok;
        load_op(all_ones);
        start = 1'b1;
        tick();
        if (!hold_start) start = 1'b0;
        if (bogus_finish) begin
            finish = 1'b1;
            result = $urandom() | 32'h1;
        end
        tick();
        finish = 1'b0;
        if (hold_start) begin
            tick();
            tick();
            start = 1'b0;
        end
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (exp_row_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) fail_event("chunk_stream_timeout");
        repeat ($urandom_range(0, 3)) tick();
        res = (all_ones || fin_with_start) ? 32'h40A0_0000 : $urandom();
        finish = 1'b1;
        result = res;
        if (fin_with_start) start = 1'b1;
        exp_res_q.push_back(res);
        exp_done_q.push_back(cyc + 2);
        tick();
        finish = 1'b0;
        start  = 1'b0;
        result = ~res;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (exp_res_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) fail_event("done_timeout");
        tick();
        tick();
    endtask

    // Resets the DUT while the first chunk is being presented.
    task automatic reset_mid_stream();
        bit ok;
        load_op(1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (outsider_read_now) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) fail_event("first_chunk_timeout");
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_addr_q.delete();
        exp_row_q.delete();
        exp_vec_q.delete();
        lat_q.delete();
        last_row = '0;
        last_vec = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        finish = 1'b0;
        result = '0;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b1;
        tick();

        run_op(1'b1, 1'b0, 1'b0, 1'b0);
        for (int t = 0; t < 8; t++) run_op(1'b0, 1'b0, 1'b0, 1'b0);
        run_op(1'b0, 1'b1, 1'b1, 1'b0);
        run_op(1'b0, 1'b0, 1'b0, 1'b1);
        for (int t = 0; t < 6; t++) begin
            run_op(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
        end
        reset_mid_stream();
        run_op(1'b0, 1'b0, 1'b0, 1'b0);
        run_op(1'b1, 1'b0, 1'b0, 1'b0);

        repeat (5) tick();
        if (exp_addr_q.size() != 0 || exp_row_q.size() != 0 || exp_res_q.size() != 0)
            fail_event("scoreboard_not_empty");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_chunk_streamer.md
VECTOR_CHUNK_STREAMER -- requirements
Module: vector_chunk_streamer

Interface
REQ-001 The block SHALL have parameter number_of_equations_per_cluster, default 16, meaning vector length N in elements.
REQ-002 The block SHALL have parameter element_width, default 32, meaning bits per element.
REQ-003 The block SHALL have parameter no_of_units, default 8, meaning elements per chunk U.
REQ-004 The block SHALL have parameter addr_width, default 8, meaning chunk address width.
REQ-005 The block SHALL use one clock and an asynchronous active-low reset, with ports named as follows:
- clk  in  1  the single clock.
- reset  in  1  asynchronous, active-low.
REQ-006 The block SHALL have the following control ports:
- start  in  1  one-cycle request to stream one dot product.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when dot_result is valid.
REQ-007 The block SHALL have the following memory read ports:
- rd_en  out  1  memory read strobe.
- rd_addr  out  addr_width  chunk index.
- rd_data_row  in  element_width*no_of_units  row chunk; valid 1 cycle after rd_en.
- rd_data_vec  in  element_width*no_of_units  vector chunk; valid 1 cycle after rd_en.
REQ-008 The block SHALL have the following dot-product unit ports:
- first_row_plus_additional  out  element_width*no_of_units  row chunk to the dot-product unit.
- vector2  out  element_width*no_of_units  vector chunk to the dot-product unit.
- outsider_read_now  out  1  chunk-valid strobe.
- result  in  element_width  dot-product sum.
- finish  in  1  result valid.
- dot_result  out  element_width  captured result.

Function
REQ-009 The block SHALL compute C = ceil(N/U) chunks, with K = N mod U valid lanes in the last chunk (all U lanes when K=0).
REQ-010 The block SHALL implement the state machine IDLE -> READ -> DRAIN -> WAIT_FIN -> IDLE.
REQ-011 In IDLE, start=1 SHALL clear the chunk counter, set busy, and enter READ; start is ignored in all other states.
REQ-012 In READ, the block SHALL assert rd_en with rd_addr = chunk counter each cycle, incrementing the counter; after issuing address C-1 it SHALL enter DRAIN.
REQ-013 The block SHALL register each chunk of read data onto the outputs, asserting outsider_read_now for exactly one cycle, 2 cycles after its rd_en.
REQ-014 Chunks SHALL stream back-to-back: C consecutive outsider_read_now cycles with no gaps, in address order 0..C-1.
REQ-015 The block SHALL leave DRAIN to WAIT_FIN once the last chunk has been presented.
REQ-016 Outside valid cycles, the chunk outputs SHALL hold their last value while outsider_read_now=0.
REQ-017 In WAIT_FIN, on the first cycle with finish=1, the block SHALL latch result into dot_result, pulse done for one cycle on the following edge, clear busy, and return to IDLE.
REQ-018 The block SHALL ignore finish=1 in any state other than WAIT_FIN.
REQ-019 When finish=1 and start=1 occur in the same cycle, the block SHALL complete the current operation; that start is dropped.
REQ-020 dot_result SHALL hold its value until the next capture.

Reset
REQ-021 reset=0 SHALL asynchronously force state IDLE, counter 0, and all outputs to 0: busy, done, rd_en, rd_addr, outsider_read_now, both chunk outputs, and dot_result.
REQ-022 Reset asserted mid-stream SHALL abort the operation without a done pulse.
REQ-023 After a mid-stream reset, the next start SHALL restart the operation from chunk 0.

Configuration
REQ-024 The macro ZERO_PAD_EN SHALL control masking of the last chunk.
REQ-025 With ZERO_PAD_EN defined, lanes K..U-1 of the last chunk SHALL be forced to zero in both chunk outputs when K>0.
REQ-026 Without ZERO_PAD_EN, memory data SHALL pass unmasked, and the memory SHALL hold zero padding.

Verification
REQ-027 N=16, U=8, start: rd_en at addresses 0,1; outsider_read_now high for 2 consecutive cycles starting 2 cycles after start; row and vector chunks match memory.
REQ-028 N=12, U=8, ZERO_PAD_EN defined, memory all 0xFFFFFFFF: the 2nd chunk has lanes 4..7 equal to 0 and lanes 0..3 equal to 0xFFFFFFFF.
REQ-029 N=12, U=8, ZERO_PAD_EN undefined, memory all 0xFFFFFFFF: the 2nd chunk has all lanes equal to 0xFFFFFFFF.
REQ-030 In WAIT_FIN, finish=1 with result=0x40A00000: dot_result=0x40A00000 and done pulses 1 cycle later; busy=0.
REQ-031 Reset driven low during the 1st chunk cycle: all outputs are 0 immediately; a following start streams from address 0.
REQ-032 start held high during READ and finish pulsed during READ: no restart and no capture; the sequence completes normally.
